// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus shared by the ALU, LSU, issue stage and register-file write port.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface reg_wb_arbiter_if #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned XLEN     = 32
);
  logic                wb_hold;

  logic                alu_valid;
  logic                alu_ready;
  logic [REG_BITS-1:0] alu_rd;
  logic [XLEN-1:0]     alu_data;

  logic                lsu_valid;
  logic                lsu_ready;
  logic [REG_BITS-1:0] lsu_rd;
  logic [XLEN-1:0]     lsu_data;

  logic                iss_claim;
  logic [REG_BITS-1:0] iss_rd;
  logic [REG_BITS-1:0] iss_rs1;
  logic [REG_BITS-1:0] iss_rs2;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                rd_busy;
  logic                claim_err;

  logic [REG_BITS-1:0] rf_a2;
  logic [XLEN-1:0]     rf_din;
  logic                rf_wr;

  modport slave (
    input  wb_hold,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  iss_claim, iss_rd, iss_rs1, iss_rs2,
    output rs1_busy, rs2_busy, rd_busy, claim_err,
    output rf_a2, rf_din, rf_wr
  );

  modport master (
    output wb_hold,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output iss_claim, iss_rd, iss_rs1, iss_rs2,
    input  rs1_busy, rs2_busy, rd_busy, claim_err,
    input  rf_a2, rf_din, rf_wr
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the register file's single write port between ALU and LSU writeback and
// tracks pending destination registers so issue can stall on RAW/WAW hazards.
module reg_wb_arbiter #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned XLEN     = 32,
  parameter bit          LSU_PRIO = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  reg_wb_arbiter_if.slave  io_wb
);

  localparam int unsigned NumRegs = 2 ** REG_BITS;

  typedef enum logic {
    SrcAlu = 1'b0,
    SrcLsu = 1'b1
  } src_e;

  src_e                r_rr_last;
  src_e                w_rr_next;

  logic                w_alu_gnt;
  logic                w_lsu_gnt;
  logic                w_alu_acc;
  logic                w_lsu_acc;
  logic                w_acc;
  logic [REG_BITS-1:0] w_acc_rd;
  logic [XLEN-1:0]     w_acc_data;
  logic                w_acc_wr;

  logic                r_rf_wr;
  logic [REG_BITS-1:0] r_rf_a2;
  logic [XLEN-1:0]     r_rf_din;

  logic [NumRegs-1:0]  r_busy;
  logic [NumRegs-1:0]  w_busy_next;
  logic                w_rs1_busy;
  logic                w_rs2_busy;
  logic                w_rd_busy;
  logic                w_same_clear;
  logic                r_claim_err;
  logic                w_claim_err_next;

  // The output stage takes a write every cycle, so grants depend only on requests and hold.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_lsu_gnt = 1'b0;
    if (!io_wb.wb_hold) begin
      if (io_wb.alu_valid && io_wb.lsu_valid) begin
        if (LSU_PRIO || (r_rr_last == SrcAlu)) begin
          w_lsu_gnt = 1'b1;
        end else begin
          w_alu_gnt = 1'b1;
        end
      end else begin
        w_alu_gnt = io_wb.alu_valid;
        w_lsu_gnt = io_wb.lsu_valid;
      end
    end
  end

  assign w_alu_acc  = io_wb.alu_valid & w_alu_gnt;
  assign w_lsu_acc  = io_wb.lsu_valid & w_lsu_gnt;
  assign w_acc      = w_alu_acc | w_lsu_acc;
  assign w_acc_rd   = w_lsu_acc ? io_wb.lsu_rd   : io_wb.alu_rd;
  assign w_acc_data = w_lsu_acc ? io_wb.lsu_data : io_wb.alu_data;
  assign w_acc_wr   = w_acc && (w_acc_rd != '0);

  always_comb begin
    w_rr_next = r_rr_last;
    if (w_alu_acc) begin
      w_rr_next = SrcAlu;
    end else if (w_lsu_acc) begin
      w_rr_next = SrcLsu;
    end
  end

  // Reset to LSU so the ALU wins the first conflict.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rr_last <= SrcLsu;
    end else begin
      r_rr_last <= w_rr_next;
    end
  end

  // Writes to x0 complete the handshake but never strobe the register file.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rf_wr  <= 1'b0;
      r_rf_a2  <= '0;
      r_rf_din <= '0;
    end else begin
      r_rf_wr <= w_acc_wr;
      if (w_acc) begin
        r_rf_a2  <= w_acc_rd;
        r_rf_din <= w_acc_data;
      end
    end
  end

  assign w_rs1_busy = (io_wb.iss_rs1 != '0) && r_busy[io_wb.iss_rs1];
  assign w_rs2_busy = (io_wb.iss_rs2 != '0) && r_busy[io_wb.iss_rs2];
  assign w_rd_busy  = (io_wb.iss_rd  != '0) && r_busy[io_wb.iss_rd];

  // Clear first, then set, so a claim on the same edge as the retiring write keeps the bit.
  always_comb begin
    w_busy_next = r_busy;
    if (w_acc_wr) begin
      w_busy_next[w_acc_rd] = 1'b0;
    end
    if (io_wb.iss_claim && (io_wb.iss_rd != '0)) begin
      w_busy_next[io_wb.iss_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  assign w_same_clear     = w_acc_wr && (w_acc_rd == io_wb.iss_rd);
  assign w_claim_err_next = io_wb.iss_claim && w_rd_busy && !w_same_clear;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_busy      <= '0;
      r_claim_err <= 1'b0;
    end else begin
      r_busy      <= w_busy_next;
      r_claim_err <= w_claim_err_next;
    end
  end

  assign io_wb.alu_ready = w_alu_gnt;
  assign io_wb.lsu_ready = w_lsu_gnt;
  assign io_wb.rs1_busy  = w_rs1_busy;
  assign io_wb.rs2_busy  = w_rs2_busy;
  assign io_wb.rd_busy   = w_rd_busy;
  assign io_wb.claim_err = r_claim_err;
  assign io_wb.rf_wr     = r_rf_wr;
  assign io_wb.rf_a2     = r_rf_a2;
  assign io_wb.rf_din    = r_rf_din;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench: round-robin and fixed-LSU instances, expected register-file writes queued
// by the stimulus and popped by per-instance monitors on the falling edge.
module tb_reg_wb_arbiter;
  localparam int unsigned RB = 5;
  localparam int unsigned XL = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_wb_arbiter_if #(.REG_BITS(RB), .XLEN(XL)) bus0 ();
  reg_wb_arbiter_if #(.REG_BITS(RB), .XLEN(XL)) bus1 ();

  reg_wb_arbiter #(.REG_BITS(RB), .XLEN(XL), .LSU_PRIO(1'b0)) u_rr (
    .i_clk (clk),
    .i_rst (rst_n),
    .io_wb (bus0)
  );

  reg_wb_arbiter #(.REG_BITS(RB), .XLEN(XL), .LSU_PRIO(1'b1)) u_fix (
    .i_clk (clk),
    .i_rst (rst_n),
    .io_wb (bus1)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] q0[$];
  logic [36:0] q1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    logic [36:0] e;
    if (rst_n && bus0.rf_wr) begin
      if (q0.size() == 0) begin
        check("rr unexpected rf_wr", 64'(bus0.rf_wr), 64'd0);
      end else begin
        e = q0.pop_front();
        check("rr rf_a2", 64'(bus0.rf_a2), 64'(e[36:32]));
        check("rr rf_din", 64'(bus0.rf_din), 64'(e[31:0]));
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [36:0] e;
    if (rst_n && bus1.rf_wr) begin
      if (q1.size() == 0) begin
        check("fix unexpected rf_wr", 64'(bus1.rf_wr), 64'd0);
      end else begin
        e = q1.pop_front();
        check("fix rf_a2", 64'(bus1.rf_a2), 64'(e[36:32]));
        check("fix rf_din", 64'(bus1.rf_din), 64'(e[31:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.wb_hold = 1'b0; bus0.iss_claim = 1'b0;
    bus0.alu_valid = 1'b0; bus0.alu_rd = '0; bus0.alu_data = '0;
    bus0.lsu_valid = 1'b0; bus0.lsu_rd = '0; bus0.lsu_data = '0;
    bus0.iss_rd = '0; bus0.iss_rs1 = '0; bus0.iss_rs2 = '0;
    bus1.wb_hold = 1'b0; bus1.iss_claim = 1'b0;
    bus1.alu_valid = 1'b0; bus1.alu_rd = '0; bus1.alu_data = '0;
    bus1.lsu_valid = 1'b0; bus1.lsu_rd = '0; bus1.lsu_data = '0;
    bus1.iss_rd = '0; bus1.iss_rs1 = '0; bus1.iss_rs2 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) step();
    check("reset rf_wr", 64'(bus0.rf_wr), 64'd0);
    check("reset rf_a2", 64'(bus0.rf_a2), 64'd0);
    check("reset rf_din", 64'(bus0.rf_din), 64'd0);
    check("reset claim_err", 64'(bus0.claim_err), 64'd0);
    check("reset fix rf_wr", 64'(bus1.rf_wr), 64'd0);
    rst_n = 1'b1;

    // Reset mid-write: claim x5, accept an ALU write to x5, reset before the edge.
    bus0.iss_claim = 1'b1; bus0.iss_rd = 5'd5;
    step();
    bus0.iss_claim = 1'b0;
    #1 check("t1 busy5 set", 64'(bus0.rd_busy), 64'd1);
    bus0.alu_valid = 1'b1; bus0.alu_rd = 5'd5; bus0.alu_data = 32'h5555_5555;
    #1 check("t1 alu_ready", 64'(bus0.alu_ready), 64'd1);
    #1 rst_n = 1'b0;
    #1 check("t1 rf_wr in reset", 64'(bus0.rf_wr), 64'd0);
    check("t1 busy5 cleared", 64'(bus0.rd_busy), 64'd0);
    idle();
    step();
    rst_n = 1'b1;
    bus0.iss_rs1 = 5'd5;
    #1 check("t1 no write after reset", 64'(bus0.rf_wr), 64'd0);
    check("t1 rs1 busy5", 64'(bus0.rs1_busy), 64'd0);
    bus0.iss_rs1 = '0;

    // Lone requests.
    bus0.alu_valid = 1'b1; bus0.alu_rd = 5'd3; bus0.alu_data = 32'hDEAD_BEEF;
    #1 check("t2 alu_ready", 64'(bus0.alu_ready), 64'd1);
    check("t2 lsu_ready idle", 64'(bus0.lsu_ready), 64'd0);
    q0.push_back({5'd3, 32'hDEAD_BEEF});
    step();
    bus0.alu_valid = 1'b0;
    bus0.lsu_valid = 1'b1; bus0.lsu_rd = 5'd0; bus0.lsu_data = 32'h0000_1234;
    #1 check("t2 lsu_ready x0", 64'(bus0.lsu_ready), 64'd1);
    check("t2 rf_wr", 64'(bus0.rf_wr), 64'd1);
    check("t2 rf_a2", 64'(bus0.rf_a2), 64'd3);
    check("t2 rf_din", 64'(bus0.rf_din), 64'hDEAD_BEEF);
    step();
    bus0.lsu_valid = 1'b0;
    #1 check("t2 x0 no rf_wr", 64'(bus0.rf_wr), 64'd0);

    // Conflicts from reset: round-robin on u_rr, LSU always on u_fix.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus0.alu_valid = 1'b1; bus0.alu_rd = 5'(10 + k); bus0.alu_data = 32'hA000_0000 + 32'(k);
      bus0.lsu_valid = 1'b1; bus0.lsu_rd = 5'(20 + k); bus0.lsu_data = 32'hB000_0000 + 32'(k);
      bus1.alu_valid = 1'b1; bus1.alu_rd = 5'(10 + k); bus1.alu_data = 32'hA000_0000 + 32'(k);
      bus1.lsu_valid = 1'b1; bus1.lsu_rd = 5'(20 + k); bus1.lsu_data = 32'hB000_0000 + 32'(k);
      #1;
      if (k % 2 == 0) begin
        check("t3 rr alu_ready", 64'(bus0.alu_ready), 64'd1);
        check("t3 rr lsu_ready", 64'(bus0.lsu_ready), 64'd0);
        q0.push_back({5'(10 + k), 32'hA000_0000 + 32'(k)});
      end else begin
        check("t3 rr alu_ready", 64'(bus0.alu_ready), 64'd0);
        check("t3 rr lsu_ready", 64'(bus0.lsu_ready), 64'd1);
        q0.push_back({5'(20 + k), 32'hB000_0000 + 32'(k)});
      end
      check("t3 fix lsu_ready", 64'(bus1.lsu_ready), 64'd1);
      check("t3 fix alu_ready", 64'(bus1.alu_ready), 64'd0);
      q1.push_back({5'(20 + k), 32'hB000_0000 + 32'(k)});
      step();
    end
    idle();

    // Scoreboard: claim x7, retire it, then claim on the same edge as the retiring write.
    bus0.iss_claim = 1'b1; bus0.iss_rd = 5'd7;
    step();
    bus0.iss_claim = 1'b0; bus0.iss_rs1 = 5'd7;
    #1 check("t4 rs1 busy7", 64'(bus0.rs1_busy), 64'd1);
    step();
    check("t4 rs1 busy7 holds", 64'(bus0.rs1_busy), 64'd1);
    bus0.alu_valid = 1'b1; bus0.alu_rd = 5'd7; bus0.alu_data = 32'h0000_0077;
    #1 check("t4 rs1 busy pre-edge", 64'(bus0.rs1_busy), 64'd1);
    check("t4 alu_ready", 64'(bus0.alu_ready), 64'd1);
    q0.push_back({5'd7, 32'h0000_0077});
    step();
    bus0.alu_valid = 1'b0;
    #1 check("t4 rs1 busy7 cleared", 64'(bus0.rs1_busy), 64'd0);
    bus0.iss_claim = 1'b1;
    step();
    bus0.alu_valid = 1'b1; bus0.alu_data = 32'h0000_0777;
    #1 check("t4 rd_busy before overlap", 64'(bus0.rd_busy), 64'd1);
    q0.push_back({5'd7, 32'h0000_0777});
    step();
    bus0.iss_claim = 1'b0; bus0.alu_valid = 1'b0;
    #1 check("t4 set wins", 64'(bus0.rs1_busy), 64'd1);
    check("t4 no claim_err", 64'(bus0.claim_err), 64'd0);
    bus0.alu_valid = 1'b1; bus0.alu_data = 32'h0000_7777;
    q0.push_back({5'd7, 32'h0000_7777});
    step();
    bus0.alu_valid = 1'b0;
    #1 check("t4 final clear", 64'(bus0.rs1_busy), 64'd0);
    bus0.iss_rs1 = '0;
    step();

    // Hold with both valid; last grant was ALU, so LSU resumes first.
    bus0.wb_hold = 1'b1;
    bus0.alu_valid = 1'b1; bus0.alu_rd = 5'd11; bus0.alu_data = 32'h0000_00C1;
    bus0.lsu_valid = 1'b1; bus0.lsu_rd = 5'd12; bus0.lsu_data = 32'h0000_00C2;
    #1 check("t5 hold alu_ready", 64'(bus0.alu_ready), 64'd0);
    check("t5 hold lsu_ready", 64'(bus0.lsu_ready), 64'd0);
    step();
    check("t5 hold rf_wr", 64'(bus0.rf_wr), 64'd0);
    step();
    check("t5 hold rf_wr 2", 64'(bus0.rf_wr), 64'd0);
    bus0.wb_hold = 1'b0;
    #1 check("t5 resume lsu", 64'(bus0.lsu_ready), 64'd1);
    check("t5 resume alu stalled", 64'(bus0.alu_ready), 64'd0);
    q0.push_back({5'd12, 32'h0000_00C2});
    step();
    check("t5 then alu", 64'(bus0.alu_ready), 64'd1);
    q0.push_back({5'd11, 32'h0000_00C1});
    step();
    idle();

    // Double claim of x9 pulses claim_err once; claims of x0 are ignored.
    bus0.iss_claim = 1'b1; bus0.iss_rd = 5'd9; bus0.iss_rs2 = 5'd9;
    step();
    check("t6 first claim no err", 64'(bus0.claim_err), 64'd0);
    check("t6 rd_busy9", 64'(bus0.rd_busy), 64'd1);
    step();
    bus0.iss_claim = 1'b0;
    #1 check("t6 claim_err pulse", 64'(bus0.claim_err), 64'd1);
    check("t6 rs2 busy9", 64'(bus0.rs2_busy), 64'd1);
    step();
    check("t6 claim_err once", 64'(bus0.claim_err), 64'd0);
    check("t6 busy9 stays", 64'(bus0.rd_busy), 64'd1);
    bus0.iss_claim = 1'b1; bus0.iss_rd = 5'd0;
    #1 check("t6 rd_busy x0", 64'(bus0.rd_busy), 64'd0);
    repeat (2) step();
    bus0.iss_claim = 1'b0;
    #1 check("t6 x0 no claim_err", 64'(bus0.claim_err), 64'd0);
    check("t6 x0 still free", 64'(bus0.rd_busy), 64'd0);

    idle();
    repeat (3) step();
    check("rr writes outstanding", 64'(q0.size()), 64'd0);
    check("fix writes outstanding", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
